// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: score write port, transport controls
// and tone/status outputs of the melody sequencer.
interface melody_sequencer_if #(
  parameter int AW = 5
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [8:0]    wr_data;
  logic [AW:0]   song_len;
  logic          play;
  logic          stop;
  logic          loop_en;
  logic [2:0]    vol;
  logic          tone;
  logic [AW-1:0] note_idx;
  logic [4:0]    note_code;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, song_len,
    output play, stop, loop_en, vol,
    input  tone, note_idx, note_code, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, song_len,
    input  play, stop, loop_en, vol,
    output tone, note_idx, note_code, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a run-time written score as a PWM
// square-wave tone with pause, stop, loop and inter-note gaps.
module melody_sequencer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int TICK_CYC = 3_125_000,
  parameter int GAP_CYC  = 250_000
) (
  input logic               clk,
  input logic               rst,
  melody_sequencer_if.slave bus
);
  localparam int PW   = $clog2(CLK_HZ / 131 + 1);
  localparam int NMAX = (15 * TICK_CYC > GAP_CYC) ?
                        15 * TICK_CYC : GAP_CYC;
  localparam int DW   = $clog2(NMAX + 1);

  typedef enum logic [1:0] {
    IDLE, PLAY, GAP, PAUSE
  } state_e;

  function automatic int per_of(input logic [4:0] p);
    case (p)
      5'd1:    per_of = CLK_HZ / 131;
      5'd2:    per_of = CLK_HZ / 147;
      5'd3:    per_of = CLK_HZ / 165;
      5'd4:    per_of = CLK_HZ / 175;
      5'd5:    per_of = CLK_HZ / 196;
      5'd6:    per_of = CLK_HZ / 220;
      5'd7:    per_of = CLK_HZ / 247;
      5'd8:    per_of = CLK_HZ / 262;
      5'd9:    per_of = CLK_HZ / 294;
      5'd10:   per_of = CLK_HZ / 330;
      5'd11:   per_of = CLK_HZ / 349;
      5'd12:   per_of = CLK_HZ / 392;
      5'd13:   per_of = CLK_HZ / 440;
      5'd14:   per_of = CLK_HZ / 494;
      5'd15:   per_of = CLK_HZ / 523;
      5'd16:   per_of = CLK_HZ / 587;
      5'd17:   per_of = CLK_HZ / 659;
      5'd18:   per_of = CLK_HZ / 698;
      5'd19:   per_of = CLK_HZ / 784;
      5'd20:   per_of = CLK_HZ / 880;
      5'd21:   per_of = CLK_HZ / 988;
      default: per_of = 1;
    endcase
  endfunction

  function automatic logic [PW-1:0] hi_of(
    input logic [PW-1:0] per,
    input logic [2:0]    v
  );
    logic [PW+3:0] prod;
    prod  = (PW+4)'(per) * (PW+4)'({1'b0, v} + 4'd1);
    hi_of = prod[PW+3:4];
  endfunction

  logic [8:0]    mem_q [DEPTH];
  state_e        state_q, state_d;
  state_e        ret_q, ret_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [PW-1:0] tcnt_q, tcnt_d;
  logic [PW-1:0] hi_q, hi_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [4:0]    pitch_q, pitch_d;
  logic          play_q;
  logic          done_q, done_d;

  logic          rise, last, fetch;
  logic [AW-1:0] fidx;
  logic [8:0]    fword;
  logic [3:0]    fdur;
  logic [PW-1:0] per_f, per_cur;
  logic [AW:0]   eff_len;

  assign rise    = bus.play & ~play_q;
  assign last    = ({1'b0, idx_q} == len_q - 1'b1);
  assign fidx    = (state_q == GAP && !last) ?
                   idx_q + 1'b1 : '0;
  assign fword   = mem_q[fidx];
  assign fdur    = (fword[3:0] == 4'd0) ? 4'd1 : fword[3:0];
  assign per_f   = PW'(per_of(fword[8:4]));
  assign per_cur = PW'(per_of(pitch_q));

  // score RAM: writes accepted in every state, never cleared
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
  end

  // next state, note/gap countdown, tone counter and fetch
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    rem_d   = rem_q;
    tcnt_d  = tcnt_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    len_d   = len_q;
    pitch_d = pitch_q;
    done_d  = 1'b0;
    fetch   = 1'b0;
    eff_len = bus.song_len;
    if (eff_len == '0)
      eff_len = (AW+1)'(1);
    else if (eff_len > (AW+1)'(DEPTH))
      eff_len = (AW+1)'(DEPTH);
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          len_d   = eff_len;
          fetch   = 1'b1;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (rise) begin
          ret_d   = PLAY;
          state_d = PAUSE;
        end else begin
          if (tcnt_q >= per_cur - 1'b1) begin
            tcnt_d = '0;
            hi_d   = hi_of(per_cur, bus.vol);
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
          if (rem_q == '0) begin
            state_d = GAP;
            rem_d   = DW'(GAP_CYC - 1);
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (rise) begin
          ret_d   = GAP;
          state_d = PAUSE;
        end else if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end else if (last && !bus.loop_en) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          fetch   = 1'b1;
          state_d = PLAY;
        end
      end
      PAUSE: begin
        if (rise) state_d = ret_q;
      end
      default: state_d = IDLE;
    endcase
    if (fetch) begin
      idx_d   = fidx;
      pitch_d = fword[8:4];
      rem_d   = DW'(int'(fdur) * TICK_CYC - 1);
      tcnt_d  = '0;
      hi_d    = hi_of(per_f, bus.vol);
    end
    if (bus.stop) begin
      state_d = IDLE;
      ret_d   = IDLE;
      rem_d   = '0;
      tcnt_d  = '0;
      hi_d    = '0;
      idx_d   = '0;
      len_d   = '0;
      pitch_d = '0;
      done_d  = 1'b0;
    end
  end

  // state and counter registers; play_q starts high so the
  // first cycle after reset cannot see a rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      rem_q   <= '0;
      tcnt_q  <= '0;
      hi_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      pitch_q <= '0;
      play_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      tcnt_q  <= tcnt_d;
      hi_q    <= hi_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      pitch_q <= pitch_d;
      play_q  <= bus.play;
      done_q  <= done_d;
    end
  end

  assign bus.tone      = (state_q == PLAY) &&
                         (pitch_q != '0) &&
                         (tcnt_q < hi_q);
  assign bus.note_code = (state_q == PLAY) ? pitch_q : '0;
  assign bus.note_idx  = idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: randomized score playback checked
// against a note-by-note behavioural model.
module tb_melody_sequencer;
  localparam int CLK  = 8000;
  localparam int TICK = 10;
  localparam int GAPC = 4;

  typedef struct packed {
    logic       tone;
    logic [4:0] code;
    logic [1:0] idx;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  int freq_t [22] = '{0, 131, 147, 165, 175, 196, 220, 247,
                      262, 294, 330, 349, 392, 440, 494,
                      523, 587, 659, 698, 784, 880, 988};
  int   sc_p [4];
  int   sc_d [4];
  obs_t exp_q [$];
  obs_t obs_q [$];

  melody_sequencer_if #(.AW(2)) bus ();

  melody_sequencer #(
    .CLK_HZ(CLK), .DEPTH(4), .AW(2),
    .TICK_CYC(TICK), .GAP_CYC(GAPC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.tone = bus.tone;
    o.code = bus.note_code;
    o.idx  = bus.note_idx;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  task automatic wr(input int a, input int p, input int d);
    sc_p[a] = p;
    sc_d[a] = d;
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(a);
    bus.wr_data = {5'(p), 4'(d)};
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // expected per-cycle outputs, starting at the first PLAY cycle
  task automatic build(input int len, input int passes,
                       input int vol, input bit fin);
    obs_t e;
    int d, per, hi;
    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < len; i++) begin
        d   = (sc_d[i] == 0) ? 1 : sc_d[i];
        per = (sc_p[i] == 0) ? 1 : CLK / freq_t[sc_p[i]];
        hi  = per * (vol + 1) / 16;
        for (int k = 0; k < d * TICK; k++) begin
          e.tone = (sc_p[i] != 0) && ((k % per) < hi);
          e.code = 5'(sc_p[i]);
          e.idx  = 2'(i);
          e.busy = 1'b1;
          e.done = 1'b0;
          exp_q.push_back(e);
        end
        for (int k = 0; k < GAPC; k++) begin
          e = '{1'b0, 5'd0, 2'(i), 1'b1, 1'b0};
          exp_q.push_back(e);
        end
      end
    end
    if (fin) begin
      e = '{1'b0, 5'd0, 2'd0, 1'b0, 1'b1};
      exp_q.push_back(e);
      e = '{1'b0, 5'd0, 2'd0, 1'b0, 1'b0};
      exp_q.push_back(e);
    end
  endtask

  task automatic run_trace(input string name);
    obs_t o;
    obs_q.delete();
    @(negedge clk);
    bus.play = 1'b1;
    foreach (exp_q[i]) begin
      @(posedge clk);
      #1;
      if (i == 0) bus.play = 1'b0;
      o = sample();
      obs_q.push_back(o);
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL %s cyc=%0d got t%b c%0d i%0d b%b d%b %s",
                 name, i, o.tone, o.code, o.idx, o.busy,
                 o.done, $sformatf("want t%b c%0d i%0d b%b d%b",
                 exp_q[i].tone, exp_q[i].code, exp_q[i].idx,
                 exp_q[i].busy, exp_q[i].done));
      end
    end
  endtask

  function automatic int high_cnt(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) c += int'(obs_q[i].tone);
    return c;
  endfunction

  task automatic test_reset();
    obs_t o;
    int nb = 0;
    bus.play = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    o = sample();
    total++;
    if (o.tone !== 1'b0) begin
      bad++; $display("FAIL rst_tone got %b want 0", o.tone);
    end
    total++;
    if (o.code !== 5'd0) begin
      bad++; $display("FAIL rst_code got %0d want 0", o.code);
    end
    total++;
    if (o.idx !== 2'd0) begin
      bad++; $display("FAIL rst_idx got %0d want 0", o.idx);
    end
    total++;
    if (o.busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got %b want 0", o.busy);
    end
    total++;
    if (o.done !== 1'b0) begin
      bad++; $display("FAIL rst_done got %b want 0", o.done);
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b0) nb++;
    end
    total++;
    if (nb != 0) begin
      bad++; $display("FAIL rst_no_rise busy_cycles=%0d want 0", nb);
    end
    @(negedge clk);
    bus.play = 1'b0;
  endtask

  task automatic test_basic(input int vol, input int hi);
    wr(0, 13, 2);
    wr(1, 0, 1);
    bus.song_len = 3'd2;
    bus.loop_en  = 1'b0;
    bus.vol      = 3'(vol);
    build(2, 1, vol, 1'b1);
    run_trace($sformatf("basic_v%0d", vol));
    total++;
    if (high_cnt(18) != hi) begin
      bad++;
      $display("FAIL high_time v%0d got %0d want %0d",
               vol, high_cnt(18), hi);
    end
    total++;
    if (obs_q[17].tone !== 1'b0 || obs_q[18].tone !== 1'b1) begin
      bad++;
      $display("FAIL period18 got t17=%b t18=%b want 0 1",
               obs_q[17].tone, obs_q[18].tone);
    end
  endtask

  task automatic test_random();
    int len, vol;
    for (int n = 0; n < 6; n++) begin
      for (int a = 0; a < 4; a++)
        wr(a, int'($urandom_range(21)), int'($urandom_range(4)));
      len = int'($urandom_range(4));
      vol = int'($urandom_range(7));
      bus.song_len = 3'(len);
      bus.vol      = 3'(vol);
      bus.loop_en  = 1'b0;
      build((len == 0) ? 1 : len, 1, vol, 1'b1);
      run_trace($sformatf("rand%0d", n));
    end
  endtask

  task automatic test_loop();
    int runs [$];
    int dn = 0;
    wr(0, 1, 1);
    wr(1, 15, 1);
    bus.song_len = 3'd2;
    bus.loop_en  = 1'b1;
    bus.vol      = 3'd7;
    build(2, 2, 7, 1'b0);
    run_trace("loop");
    foreach (obs_q[i]) begin
      if (runs.size() == 0 || runs[$] != int'(obs_q[i].idx))
        runs.push_back(int'(obs_q[i].idx));
      if (obs_q[i].done !== 1'b0 || obs_q[i].busy !== 1'b1)
        dn++;
    end
    total++;
    if (runs.size() != 4 || runs[0] != 0 || runs[1] != 1 ||
        runs[2] != 0 || runs[3] != 1) begin
      bad++;
      $display("FAIL loop_seq got %0d runs want 0,1,0,1",
               runs.size());
    end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL loop_busy_done got %0d bad cycles want 0", dn);
    end
    @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL loop_stop busy got %b want 0", bus.busy);
    end
    @(negedge clk);
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int nb = 0;
    int cnt = 0;
    int ph = 0;
    bit got_done = 1'b0;
    wr(0, 13, 2);
    bus.song_len = 3'd1;
    bus.vol      = 3'd7;
    @(negedge clk);
    bus.play = 1'b1;
    @(negedge clk);
    bus.play = 1'b0;
    repeat (5) @(negedge clk);
    bus.play = 1'b1;
    @(negedge clk);
    bus.play = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (bus.tone !== 1'b0 || bus.busy !== 1'b1 ||
          bus.note_code !== 5'd0) nb++;
    end
    total++;
    if (nb != 0) begin
      bad++; $display("FAIL pause_silent got %0d bad cycles want 0", nb);
    end
    @(negedge clk);
    bus.play = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) bus.play = 1'b0;
      if (bus.note_code !== 5'd13) break;
      if (bus.tone !== 1'(((5 + cnt) % 18) < 9)) ph++;
      cnt++;
    end
    total++;
    if (cnt != 15) begin
      bad++; $display("FAIL resume_len got %0d want 15", cnt);
    end
    total++;
    if (ph != 0) begin
      bad++; $display("FAIL resume_phase got %0d bad cycles want 0", ph);
    end
    for (int j = 0; j < 30 && !got_done; j++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) got_done = 1'b1;
    end
    total++;
    if (!got_done) begin
      bad++; $display("FAIL pause_done got 0 want 1 within 30 cycles");
    end
  endtask

  task automatic test_stop_gap();
    bit in_gap = 1'b0;
    int dn = 0;
    wr(0, 13, 1);
    wr(1, 10, 1);
    bus.song_len = 3'd2;
    bus.loop_en  = 1'b0;
    @(negedge clk);
    bus.play = 1'b1;
    for (int j = 0; j < 40 && !in_gap; j++) begin
      @(posedge clk);
      #1;
      if (j == 0) bus.play = 1'b0;
      if (bus.busy === 1'b1 && bus.note_code === 5'd0)
        in_gap = 1'b1;
    end
    total++;
    if (!in_gap) begin
      bad++; $display("FAIL stop_reach_gap got 0 want 1");
    end
    @(negedge clk);
    bus.stop = 1'b1;
    bus.play = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (sample() !== obs_t'(0)) begin
      bad++;
      $display("FAIL stop_idle got %b want 0", sample());
    end
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dn++;
    end
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL stop_quiet got %0d bad cycles want 0", dn);
    end
    @(negedge clk);
    bus.play = 1'b0;
  endtask

  task automatic test_dur0_rst();
    int nz = 0;
    wr(0, 13, 0);
    bus.song_len = 3'd1;
    bus.vol      = 3'd7;
    build(1, 1, 7, 1'b1);
    run_trace("dur0");
    @(negedge clk);
    bus.play = 1'b1;
    @(negedge clk);
    bus.play = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1 || bus.note_code !== 5'd13) begin
      bad++;
      $display("FAIL rst_pre got b%b c%0d want b1 c13",
               bus.busy, bus.note_code);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (sample() !== obs_t'(0)) begin
      bad++; $display("FAIL rst_async got %b want 0", sample());
    end
    #1;
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (sample() !== obs_t'(0)) nz++;
    end
    total++;
    if (nz != 0) begin
      bad++; $display("FAIL rst_hold got %0d bad cycles want 0", nz);
    end
    run_trace("after_rst");
  endtask

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.song_len = '0;
    bus.play     = 1'b0;
    bus.stop     = 1'b0;
    bus.loop_en  = 1'b0;
    bus.vol      = 3'd7;
    test_reset();
    test_basic(7, 9);
    test_basic(3, 4);
    test_random();
    test_loop();
    test_pause();
    test_stop_gap();
    test_dur0_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
